// File: rtl/io_responder.sv
// Memory-mapped I/O responder: sprite regs, frame counter, sticky status, 8-bit TX FIFO.
// Latency: reads are combinational from io_addr; writes land on the next rising clock edge.
// Backpressure: the TX FIFO holds bytes while tx_ready=0; a push into a full FIFO with no pop is dropped and sets OVERFLOW.
// Optional build macro IO_RESPONDER_TIMER_EN adds TIMER (0x6), TIMER_CMP (0x7) and STATUS bit8 TMATCH.
module io_responder #(
   parameter int WIDTH      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] io_addr,
   output logic [WIDTH-1:0] io_rd_data,
   input  logic             io_write,
   input  logic [WIDTH-1:0] io_wr_data,
   input  logic             frame_tick,
   output logic [WIDTH-1:0] sprite_x,
   output logic [WIDTH-1:0] sprite_y,
   output logic             sprite_en,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [3:0] IDX_X      = 4'h0;
   localparam logic [3:0] IDX_Y      = 4'h1;
   localparam logic [3:0] IDX_CTRL   = 4'h2;
   localparam logic [3:0] IDX_FRAME  = 4'h3;
   localparam logic [3:0] IDX_STATUS = 4'h4;
   localparam logic [3:0] IDX_TX     = 4'h5;
`ifdef IO_RESPONDER_TIMER_EN
   localparam logic [3:0] IDX_TIMER  = 4'h6;
   localparam logic [3:0] IDX_TCMP   = 4'h7;
`endif

   logic [WIDTH-1:0] r_sprite_x;
   logic [WIDTH-1:0] r_sprite_y;
   logic             r_sprite_en;
   logic [WIDTH-1:0] r_frame_cnt;
   logic             r_vsync;
   logic             r_overflow;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;

   logic             w_sel;
   logic [3:0]       w_idx;
   logic             w_wr;
   logic             w_wr_status;
   logic             w_wr_tx;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push_ok;
   logic             w_ovf_evt;
   logic [WIDTH-1:0] w_status;

   // Middle address bits only create aliases; they carry no meaning here.
   logic             w_unused_addr;
   assign w_unused_addr = ^io_addr[WIDTH-3:4];

   assign w_sel       = (io_addr[WIDTH-1 -: 2] != 2'b00);
   assign w_idx       = io_addr[3:0];
   assign w_wr        = io_write && w_sel;
   assign w_wr_status = w_wr && (w_idx == IDX_STATUS);
   assign w_wr_tx     = w_wr && (w_idx == IDX_TX);

   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   // A pop needs a valid head, so an empty FIFO never pops even with a same-cycle push.
   assign w_pop     = !w_empty && tx_ready;
   // Pushing into a full FIFO is fine when the head leaves in the same cycle.
   assign w_push_ok = w_wr_tx && (!w_full || w_pop);
   assign w_ovf_evt = w_wr_tx && w_full && !w_pop;

   assign sprite_x  = r_sprite_x;
   assign sprite_y  = r_sprite_y;
   assign sprite_en = r_sprite_en;
   assign tx_valid  = !w_empty;
   assign tx_data   = r_mem[r_rd_ptr];

`ifdef IO_RESPONDER_TIMER_EN
   logic [WIDTH-1:0] r_timer;
   logic [WIDTH-1:0] r_timer_cmp;
   logic             r_tmatch;
   logic [WIDTH-1:0] w_timer_nxt;
   logic [WIDTH-1:0] w_cmp_nxt;

   assign w_timer_nxt = (w_wr && (w_idx == IDX_TIMER)) ? io_wr_data : r_timer + WIDTH'(1);
   assign w_cmp_nxt   = (w_wr && (w_idx == IDX_TCMP))  ? io_wr_data : r_timer_cmp;

   // Free-running timer and compare register; TMATCH is judged on the values both registers take at this edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_timer     <= '0;
         r_timer_cmp <= '0;
         r_tmatch    <= 1'b0;
      end else begin
         r_timer     <= w_timer_nxt;
         r_timer_cmp <= w_cmp_nxt;
         if (w_timer_nxt == w_cmp_nxt)
            r_tmatch <= 1'b1;
         else if (w_wr_status && io_wr_data[8])
            r_tmatch <= 1'b0;
      end
   end
`endif

   // Assemble the STATUS word from flags and FIFO occupancy.
   always_comb begin
      w_status      = '0;
      w_status[0]   = r_vsync;
      w_status[1]   = w_full;
      w_status[2]   = w_empty;
      w_status[3]   = r_overflow;
      w_status[7:4] = 4'(r_count);
`ifdef IO_RESPONDER_TIMER_EN
      w_status[8]   = r_tmatch;
`endif
   end

   // Zero-latency read mux; unselected or unmapped addresses read 0.
   always_comb begin
      io_rd_data = '0;
      if (w_sel) begin
         case (w_idx)
            IDX_X:      io_rd_data = r_sprite_x;
            IDX_Y:      io_rd_data = r_sprite_y;
            IDX_CTRL:   io_rd_data = {{(WIDTH-1){1'b0}}, r_sprite_en};
            IDX_FRAME:  io_rd_data = r_frame_cnt;
            IDX_STATUS: io_rd_data = w_status;
`ifdef IO_RESPONDER_TIMER_EN
            IDX_TIMER:  io_rd_data = r_timer;
            IDX_TCMP:   io_rd_data = r_timer_cmp;
`endif
            default:    io_rd_data = '0;
         endcase
      end
   end

   // Sprite position and control registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sprite_x  <= '0;
         r_sprite_y  <= '0;
         r_sprite_en <= 1'b0;
      end else if (w_wr) begin
         if (w_idx == IDX_X)    r_sprite_x  <= io_wr_data;
         if (w_idx == IDX_Y)    r_sprite_y  <= io_wr_data;
         if (w_idx == IDX_CTRL) r_sprite_en <= io_wr_data[0];
      end
   end

   // Frame counter; a write clears it and beats a coincident tick.
   always_ff @(posedge clock) begin
      if (reset)
         r_frame_cnt <= '0;
      else if (w_wr && (w_idx == IDX_FRAME))
         r_frame_cnt <= '0;
      else if (frame_tick)
         r_frame_cnt <= r_frame_cnt + WIDTH'(1);
   end

   // Sticky VSYNC and OVERFLOW flags; write-1-to-clear, a same-cycle set wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_vsync    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (frame_tick)
            r_vsync <= 1'b1;
         else if (w_wr_status && io_wr_data[0])
            r_vsync <= 1'b0;
         if (w_ovf_evt)
            r_overflow <= 1'b1;
         else if (w_wr_status && io_wr_data[3])
            r_overflow <= 1'b0;
      end
   end

   // Circular TX buffer; reset discards contents and zeroes storage so tx_data reads 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= 8'h00;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= io_wr_data[7:0];
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped I/O peripheral on the stack CPU's I/O bus; the responder end of the CPU's io_addr/io_rd_data/io_write/io_wr_data interface.
- Holds sprite position/control registers, a frame counter, sticky status flags, and a small transmit FIFO that the CPU fills and a downstream sink drains.
- Sits beside CPURAM in the top level. The CPU already steers accesses whose top two address bits are non-zero to io_write; this block decodes the same region.

Parameters:
- WIDTH, 16, data/address width; equals CPU_WIDTH.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2, minimum 2.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- io_addr  input  WIDTH  CPU I/O address
- io_rd_data  output  WIDTH  read data, combinational from io_addr
- io_write  input  1  write strobe, one cycle per store
- io_wr_data  input  WIDTH  write data
- frame_tick  input  1  one-cycle pulse per video frame
- sprite_x  output  WIDTH  sprite X position
- sprite_y  output  WIDTH  sprite Y position
- sprite_en  output  1  sprite enable
- tx_data  output  8  FIFO head byte
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  sink accepts head byte

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Select: sel = (io_addr[WIDTH-1:WIDTH-2] != 0). Register index = io_addr[3:0]. Bits [WIDTH-3:4] are ignored, so registers alias across the region.
- Reads: io_rd_data is a pure combinational mux with zero latency; the CPU samples it on the same edge. Reads have no side effects. When sel=0, or the index is unmapped, read value is 0.
- Writes: take effect on the rising edge when io_write && sel. Writes to unmapped or read-only indices are ignored.
- Register map:
  - 0x0 SPRITE_X: rw, drives sprite_x.
  - 0x1 SPRITE_Y: rw, drives sprite_y.
  - 0x2 CTRL: rw. Bit0 drives sprite_en; other bits read 0.
  - 0x3 FRAME_CNT: increments by 1 per frame_tick and wraps at 2^WIDTH. Any write clears it to 0. A write and a tick in the same cycle give 0.
  - 0x4 STATUS:
    - bit0 VSYNC: set by frame_tick.
    - bit1 FULL.
    - bit2 EMPTY.
    - bit3 OVERFLOW: sticky.
    - bits[7:4]: FIFO count.
    - Writing 1 to bit0 or bit3 clears that bit; writing 0 has no effect. If a set and a clear hit the same cycle, set wins.
  - 0x5 TX: write pushes io_wr_data[7:0] into the FIFO. Reads return 0.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits and a count of log2(FIFO_DEPTH)+1 bits.
  - tx_valid = (count != 0); tx_data = head entry, stable while tx_valid && !tx_ready.
  - Pop occurs when tx_valid && tx_ready.
  - Push when not full: accepted.
  - Push when full with no pop in the same cycle: data dropped, OVERFLOW set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: only the push occurs; a pop requires tx_valid.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values: sprite_x=0, sprite_y=0, sprite_en=0, FRAME_CNT=0, VSYNC=0, OVERFLOW=0. FIFO is emptied (count=0, tx_valid=0); tx_data=0.
- Reset mid-transfer: the FIFO contents are discarded and tx_valid drops in the cycle after the reset edge.

Optional Feature:
- Macro: IO_RESPONDER_TIMER_EN.
- When defined:
  - Index 0x6 TIMER is a free-running cycle counter that increments every clock and wraps.
  - A write loads io_wr_data, and counting resumes from that value on the next edge.
  - Index 0x7 TIMER_CMP is rw; when TIMER == TIMER_CMP, STATUS bit8 (TMATCH) is set. TMATCH is sticky and cleared by writing 1.
  - Both registers and TMATCH reset to 0.
- When undefined: 0x6 and 0x7 read 0, writes are ignored, and STATUS bit8 reads 0.

Test Plan:
- Write 0x4000|0x0 with 0x0123, then 0x4001 with 0x0045, then 0x4002 with 0x0001 -> sprite_x=0x0123, sprite_y=0x0045, sprite_en=1. Reading 0x4010 returns 0x0123 (alias). Reading 0x0000 returns 0.
- Pulse frame_tick 3 times -> FRAME_CNT=3 and STATUS bit0=1. Write 0x0001 to 0x4004 -> bit0=0, FRAME_CNT still 3. Any write to 0x4003 -> 0.
- tx_ready=0; push 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x0042|0x8 (count 4, FULL, OVERFLOW). Raise tx_ready -> bytes 0x41..0x44 out in order, then EMPTY=1, tx_valid=0.
- FIFO full with tx_ready=1 and a push of 0x55 in the same cycle -> count stays 4, OVERFLOW stays 0, 0x55 emerges last.
- Assert reset for 1 cycle with 2 bytes queued and sprite_en=1 -> next cycle tx_valid=0, sprite_en=0, FRAME_CNT=0, STATUS=0x0004.
- With IO_RESPONDER_TIMER_EN: write TIMER=0, TIMER_CMP=10 -> TMATCH=1 ten cycles after the load edge. Without the macro, a read of 0x4006 returns 0.
